// File: rtl/sfifo_rd_control_if.sv
// Consumer-side pop handshake of the synchronous FIFO read controller.
// The consumer sees the head word on DataOut/DataValid and pops with FIFORdReq.
interface sfifo_rd_control_if #(
    parameter int DataWidth = 8
);
    logic                 FIFORdReq;
    logic [DataWidth-1:0] DataOut;
    logic                 DataValid;

    modport master (output FIFORdReq, input DataOut, input DataValid);
    modport slave  (input FIFORdReq, output DataOut, output DataValid);
endinterface

// File: rtl/sfifo_rd_control.sv
// Read-side controller of the synchronous FIFO: RAM read pointer, two-entry
// first-word-fall-through output buffer, occupancy and sticky underflow status.
module sfifo_rd_control #(
    parameter int AddrLines     = 8,
    parameter int DataWidth     = 8,
    parameter int AlmostEmptyTh = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AddrLines:0]   SyncWrAddr,
    input  logic [DataWidth-1:0] RdData,
    input  logic                 UnderflowClr,
    output logic                 RdEn,
    output logic [AddrLines-1:0] RdAddr,
    output logic [AddrLines:0]   SyncRdAddr,
    output logic                 MemEmpty,
    output logic [AddrLines+1:0] TotalLevel,
    output logic                 AlmostEmpty,
    output logic                 Underflow,
    sfifo_rd_control_if.slave    pop_if
);
    localparam int PW = AddrLines + 1;
    localparam int LW = AddrLines + 2;

    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 pending_q;
    logic [1:0]           buf_cnt_q, buf_cnt_d;
    logic [DataWidth-1:0] head_q, head_d;
    logic [DataWidth-1:0] skid_q, skid_d;
    logic                 underflow_q, underflow_d;

    logic                 valid_s;
    logic                 pop_s;
    logic                 mem_empty_s;
    logic                 rd_en_s;
    logic [PW-1:0]        mem_level_s;
    logic [2:0]           occ_s;
    logic [1:0]           cnt_after_s;

    // Pop/read decision and next state of pointer, buffer and status.
    always_comb begin
        valid_s     = (buf_cnt_q != 2'd0);
        pop_s       = pop_if.FIFORdReq & valid_s;
        mem_empty_s = (rd_ptr_q == SyncWrAddr);
        mem_level_s = SyncWrAddr - rd_ptr_q;
        // Slots still committed after this cycle; a read is only issued if
        // its returning word is guaranteed a free slot.
        occ_s       = {1'b0, buf_cnt_q} + {2'b00, pending_q} - {2'b00, pop_s};
        rd_en_s     = !mem_empty_s && (occ_s < 3'd2);
        cnt_after_s = buf_cnt_q - {1'b0, pop_s};

        head_d = head_q;
        skid_d = skid_q;
        if (pop_s) begin
            head_d = skid_q;
        end else begin
            head_d = head_q;
        end
        // The returning RAM word lands in the first slot free after the pop.
        if (pending_q) begin
            if (cnt_after_s == 2'd0) begin
                head_d = RdData;
            end else begin
                skid_d = RdData;
            end
        end else begin
            skid_d = skid_d;
        end
        buf_cnt_d = cnt_after_s + {1'b0, pending_q};

        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (pop_if.FIFORdReq && !valid_s) begin
            underflow_d = 1'b1;
        end else if (UnderflowClr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State registers; reset drops buffered and in-flight words at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= {PW{1'b0}};
            pending_q   <= 1'b0;
            buf_cnt_q   <= 2'd0;
            head_q      <= {DataWidth{1'b0}};
            skid_q      <= {DataWidth{1'b0}};
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            pending_q   <= rd_en_s;
            buf_cnt_q   <= buf_cnt_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            underflow_q <= underflow_d;
        end
    end

    assign RdEn             = rd_en_s;
    assign RdAddr           = rd_ptr_q[AddrLines-1:0];
    assign SyncRdAddr       = rd_ptr_q;
    assign MemEmpty         = mem_empty_s;
    assign TotalLevel       = {1'b0, mem_level_s} + LW'(pending_q) + LW'(buf_cnt_q);
    assign AlmostEmpty      = (TotalLevel <= LW'(AlmostEmptyTh));
    assign Underflow        = underflow_q;
    assign pop_if.DataOut   = head_q;
    assign pop_if.DataValid = valid_s;
endmodule

// File: doc/sfifo_rd_control.md
Name: sfifo_rd_control

Overview:
- Read-side controller for the synchronous FIFO. It is the counterpart of the write controller and shares the same dual-port RAM and (AddrLines+1)-bit pointer scheme.
- It generates the RAM read enable and address, and owns the read pointer that is returned to the write side for the full check.
- It adds a first-word-fall-through (FWFT) output stage so the consumer sees the head word and pops with a valid/ready-style request.
- It provides occupancy, almost-empty and sticky underflow status.

Parameters:
- AddrLines, 8: RAM address width; memory depth is 2^AddrLines.
- DataWidth, 8: word width.
- AlmostEmptyTh, 2: AlmostEmpty asserts when TotalLevel <= AlmostEmptyTh.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- SyncWrAddr  in  AddrLines+1  write pointer from the write controller; the MSB is the wrap bit.
- RdData  in  DataWidth  RAM read data, registered, valid one cycle after RdEn.
- FIFORdReq  in  1  consumer pop; takes effect only when DataValid=1.
- UnderflowClr  in  1  clears Underflow.
- RdEn  out  1  RAM read enable.
- RdAddr  out  AddrLines  equals SyncRdAddr[AddrLines-1:0].
- SyncRdAddr  out  AddrLines+1  read pointer, registered.
- MemEmpty  out  1  RAM holds no unread word.
- DataOut  out  DataWidth  head word; meaningful only while DataValid=1.
- DataValid  out  1  head word present.
- TotalLevel  out  AddrLines+2  words in RAM + in flight + buffered.
- AlmostEmpty  out  1  TotalLevel <= AlmostEmptyTh.
- Underflow  out  1  sticky: a pop was attempted while DataValid=0.

Behaviour:
- Reset values (asynchronous):
  - SyncRdAddr=0; Pending=0; BufCnt=0; head/skid data=0; Underflow=0.
  - Outputs therefore reset to DataValid=0, DataOut=0, MemEmpty=1, TotalLevel=0, AlmostEmpty=1.
- Reset mid-operation discards buffered and in-flight words immediately. A RAM word returning after reset is ignored.
- Memory-side state:
  - MemEmpty = (SyncRdAddr == SyncWrAddr), full-width compare, combinational.
  - MemLevel = SyncWrAddr - SyncRdAddr, modulo 2^(AddrLines+1). This is correct across pointer wrap.
- Output buffer: 2 entries, head then skid, strict FIFO order.
  - BufCnt is 0..2.
  - Pending is a 1-bit register equal to RdEn of the previous cycle.
- Pop: Pop = FIFORdReq & DataValid.
- Read-enable rule (combinational): RdEn = !MemEmpty & (BufCnt + Pending - Pop < 2).
  - This guarantees the returning word always has a slot.
  - It sustains one word per cycle under continuous pop.
- On each clock edge:
  - If RdEn: SyncRdAddr += 1 (wraps naturally at 2^(AddrLines+1)).
  - Pending <= RdEn.
  - If Pending: RdData is written to the first free slot after applying this cycle's Pop.
  - If Pop: skid shifts to head.
  - Pop and arrival in the same cycle are both applied; BufCnt changes by Pending - Pop.
- DataValid = (BufCnt != 0); DataOut = head entry.
- Latency: a word whose write moves SyncWrAddr at edge E is seen combinationally in the next cycle.
  - RdEn asserts in that cycle, at edge E+1.
  - DataValid rises after edge E+2.
- TotalLevel = MemLevel + Pending + BufCnt. Maximum is 2^AddrLines + 2, since words moved out of RAM free RAM space for the writer.
- Underflow:
  - Set on any cycle with FIFORdReq=1 and DataValid=0. Nothing else changes: no pointer move, no read.
  - Cleared by UnderflowClr; set has priority when both occur in the same cycle.
- FIFORdReq while DataValid=1 is never an error.
- The RAM is never read when MemEmpty=1. The pointer never passes SyncWrAddr.

Test Plan (AddrLines=3, DataWidth=8, AlmostEmptyTh=2):
1. Reset, then hold: DataValid=0, MemEmpty=1, SyncRdAddr=0, TotalLevel=0, AlmostEmpty=1, RdEn=0 every cycle.
2. Write 0xA1 (SyncWrAddr 0->1) with no pops:
   - RdEn=1 exactly one cycle later; DataValid=1 two edges after the pointer change; DataOut=0xA1.
   - TotalLevel=1 throughout; SyncRdAddr=1, MemEmpty=1.
3. Preload 10 words 0x00..0x09 with FIFORdReq low:
   - RAM supplies 8 (SyncWrAddr 0->8, writer then full); the controller prefetches 2, so SyncRdAddr=2 and BufCnt=2, freeing 2 RAM slots.
   - The writer completes the last 2 (SyncWrAddr=10); TotalLevel=10, DataOut=0x00.
   - Continuous FIFORdReq then drains 0x00..0x09 in order, one per cycle, no bubbles. DataValid falls after the 10th pop, and SyncRdAddr=10 (wrap bit set, RdAddr=2).
4. FIFORdReq=1 while DataValid=0: Underflow=1 and stays set. Assert UnderflowClr with FIFORdReq=0: Underflow=0 next cycle.
5. Simultaneous write and pop at level 1, repeated 20 cycles:
   - TotalLevel stays 1 (±1 transient per latency); data in order.
   - Pointers wrap past 15->0 with MemEmpty correct.
6. Assert reset with BufCnt=2 and Pending=1: all outputs go to reset values immediately. After reset release, the RAM word from the earlier read is not presented.
